// File: rtl/keccak_sponge_buffer_pkg.sv
// Shared constants, FSM state type and lane indexing for the Keccak sponge buffer.
package keccak_pkg;

    localparam int unsigned LANE_W     = 64;
    localparam int unsigned NUM_LANES  = 25;
    localparam int unsigned RATE_LANES = 17;
    localparam int unsigned OUT_LANES  = 4;

    localparam logic [LANE_W-1:0] SHA3_PAD_LO = 64'h06;
    localparam logic [LANE_W-1:0] SHA3_PAD_HI = 64'h8000000000000000;

    typedef enum logic [2:0] {
        ABSORB,
        PAD,
        SEND,
        PERM,
        SQUEEZE
    } state_t;

    function automatic logic [4:0] lane_idx(input logic [2:0] x, input logic [2:0] y);
        return 5'(5 * y + x);
    endfunction

endpackage

// File: rtl/keccak_sponge_buffer_slice_mux.sv
// Extracts slice z (one bit from every lane, bit 5*y+x = lane(x,y)[z]) from the 25x64 state.
module keccak_slice_mux
    import keccak_pkg::*;
(
    input  logic [LANE_W-1:0]    i_state [NUM_LANES],
    input  logic [5:0]           i_z,
    output logic [NUM_LANES-1:0] o_slice
);

    always_comb begin
        o_slice = '0;
        for (int unsigned y = 0; y < 5; y++) begin
            for (int unsigned x = 0; x < 5; x++) begin
                o_slice[lane_idx(3'(x), 3'(y))] = i_state[lane_idx(3'(x), 3'(y))][i_z];
            end
        end
    end

endmodule

// File: rtl/keccak_sponge_buffer.sv
// Keccak-f[1600] state holder: absorbs rate lanes, streams slices to the round datapath, takes write-backs, squeezes a 256-bit digest.
// Optional hardware SHA3 pad10*1 when KECCAK_PAD_EN is defined.
module keccak_sponge_buffer
    import keccak_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_lane,
    input  logic        in_last,
    output logic        slice_valid,
    input  logic        slice_ready,
    output logic [24:0] slice_out,
    output logic [5:0]  slice_z,
    input  logic        wb_valid,
    input  logic [5:0]  wb_z,
    input  logic [24:0] wb_slice,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_lane,
    output logic        busy
);

    localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);
    localparam logic [4:0] LAST_OUT  = 5'(OUT_LANES - 1);

    logic [LANE_W-1:0]    r_lane [NUM_LANES];
    state_t               r_state;
    logic [4:0]           r_lane_cnt;
    logic [5:0]           r_z_cnt;
    logic [5:0]           r_wb_cnt;
    logic                 r_last_flag;
`ifdef KECCAK_PAD_EN
    logic [4:0]           r_pad_lane;
    logic                 r_pad_pending;
`endif

    logic [NUM_LANES-1:0] w_send_slice;
    logic [NUM_LANES-1:0] w_wb_old;
    logic [NUM_LANES-1:0] w_wb_diff;

    keccak_slice_mux u_send_mux (
        .i_state (r_lane),
        .i_z     (r_z_cnt),
        .o_slice (w_send_slice)
    );

    // Write-back scatter: read the current slice at wb_z and XOR in only the changed bits.
    keccak_slice_mux u_wb_mux (
        .i_state (r_lane),
        .i_z     (wb_z),
        .o_slice (w_wb_old)
    );

    assign w_wb_diff   = w_wb_old ^ wb_slice;

    assign in_ready    = (r_state == ABSORB);
    assign busy        = (r_state != ABSORB);
    assign slice_valid = (r_state == SEND);
    assign out_valid   = (r_state == SQUEEZE);
    assign slice_out   = slice_valid ? w_send_slice : '0;
    assign slice_z     = r_z_cnt;
    assign out_lane    = out_valid ? r_lane[r_lane_cnt] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_LANES; k++) r_lane[k] <= '0;
            r_state     <= ABSORB;
            r_lane_cnt  <= '0;
            r_z_cnt     <= '0;
            r_wb_cnt    <= '0;
            r_last_flag <= 1'b0;
`ifdef KECCAK_PAD_EN
            r_pad_lane    <= '0;
            r_pad_pending <= 1'b0;
`endif
        end else begin
            case (r_state)
                ABSORB: begin
                    if (in_valid) begin
                        r_lane[r_lane_cnt] <= r_lane[r_lane_cnt] ^ in_lane;
                        if (in_last) r_last_flag <= 1'b1;
                        if (r_lane_cnt == LAST_RATE) begin
                            r_lane_cnt <= '0;
                            r_state    <= SEND;
`ifdef KECCAK_PAD_EN
                            if (in_last) r_pad_pending <= 1'b1;
`endif
                        end else begin
                            r_lane_cnt <= r_lane_cnt + 5'd1;
`ifdef KECCAK_PAD_EN
                            if (in_last) begin
                                r_lane_cnt <= '0;
                                r_pad_lane <= r_lane_cnt + 5'd1;
                                r_state    <= PAD;
                            end
`endif
                        end
                    end
                end
`ifdef KECCAK_PAD_EN
                PAD: begin
                    if (r_pad_lane == LAST_RATE) begin
                        r_lane[LAST_RATE] <= r_lane[LAST_RATE] ^ SHA3_PAD_HI ^ SHA3_PAD_LO;
                    end else begin
                        r_lane[r_pad_lane] <= r_lane[r_pad_lane] ^ SHA3_PAD_LO;
                        r_lane[LAST_RATE]  <= r_lane[LAST_RATE] ^ SHA3_PAD_HI;
                    end
                    r_state <= SEND;
                end
`endif
                SEND: begin
                    if (slice_ready) begin
                        if (r_z_cnt == 6'd63) begin
                            r_z_cnt <= '0;
                            r_state <= PERM;
                        end else begin
                            r_z_cnt <= r_z_cnt + 6'd1;
                        end
                    end
                end
                PERM: begin
                    if (wb_valid) begin
                        for (int unsigned k = 0; k < NUM_LANES; k++) begin
                            r_lane[k] <= r_lane[k] ^ (64'(w_wb_diff[k]) << wb_z);
                        end
                        if (r_wb_cnt == 6'd63) begin
                            r_wb_cnt <= '0;
                            if (r_last_flag) begin
`ifdef KECCAK_PAD_EN
                                // A full final block still owes a padding-only block before squeezing.
                                if (r_pad_pending) begin
                                    r_pad_pending <= 1'b0;
                                    r_pad_lane    <= '0;
                                    r_state       <= PAD;
                                end else
`endif
                                r_state <= SQUEEZE;
                            end else begin
                                r_state <= ABSORB;
                            end
                        end else begin
                            r_wb_cnt <= r_wb_cnt + 6'd1;
                        end
                    end
                end
                SQUEEZE: begin
                    if (out_ready) begin
                        if (r_lane_cnt == LAST_OUT) begin
                            for (int unsigned k = 0; k < NUM_LANES; k++) r_lane[k] <= '0;
                            r_last_flag <= 1'b0;
                            r_lane_cnt  <= '0;
                            r_state     <= ABSORB;
                        end else begin
                            r_lane_cnt <= r_lane_cnt + 5'd1;
                        end
                    end
                end
                default: r_state <= ABSORB;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_sponge_buffer.sv
// Scoreboard bench for keccak_sponge_buffer (default build): random blocks, random write-back permutations, random stalls.
module tb_keccak_sponge_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [63:0] in_lane;
    logic        slice_valid, slice_ready;
    logic [24:0] slice_out;
    logic [5:0]  slice_z;
    logic        wb_valid;
    logic [5:0]  wb_z;
    logic [24:0] wb_slice;
    logic        out_valid, out_ready;
    logic [63:0] out_lane;
    logic        busy;

    always #5 clk = ~clk;

    keccak_sponge_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lane     (in_lane),
        .in_last     (in_last),
        .slice_valid (slice_valid),
        .slice_ready (slice_ready),
        .slice_out   (slice_out),
        .slice_z     (slice_z),
        .wb_valid    (wb_valid),
        .wb_z        (wb_z),
        .wb_slice    (wb_slice),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lane    (out_lane),
        .busy        (busy)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference: the 25 lanes as the specification defines them, plus expected stream contents.
    logic [63:0] model [25];
    logic [63:0] blk [17];
    typedef struct packed {
        logic [5:0]  z;
        logic [24:0] s;
    } slice_exp_t;
    slice_exp_t  exp_slices [$];
    logic [63:0] exp_out [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic abort(input string name);
        n_fail++;
        $display("FAIL %s: cycle bound expired waiting for a handshake", name);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "bench stopped early");
    endtask

    function automatic logic [24:0] model_slice(input int z);
        logic [24:0] s;
        for (int k = 0; k < 25; k++) s[k] = model[k][z];
        return s;
    endfunction

    // Monitor: pops expectations on every handshake, and checks outputs stay put while stalled.
    logic        prev_s_stall = 1'b0, prev_o_stall = 1'b0;
    logic [5:0]  prev_z;
    logic [24:0] prev_s;
    logic [63:0] prev_o;
    always @(negedge clk) begin
        slice_exp_t e;
        if (slice_valid) begin
            if (prev_s_stall) begin
                check("slice_z held in stall", 64'(slice_z), 64'(prev_z));
                check("slice_out held in stall", 64'(slice_out), 64'(prev_s));
            end
            if (slice_ready) begin
                if (exp_slices.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected slice: got z=%0d, required none", slice_z);
                end else begin
                    e = exp_slices.pop_front();
                    check("slice_z order", 64'(slice_z), 64'(e.z));
                    check("slice_out value", 64'(slice_out), 64'(e.s));
                end
            end
        end
        if (out_valid) begin
            if (prev_o_stall) check("out_lane held in stall", out_lane, prev_o);
            if (out_ready) begin
                if (exp_out.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected out lane: got %h, required none", out_lane);
                end else begin
                    check("out_lane value", out_lane, exp_out.pop_front());
                end
            end
        end
        prev_s_stall = slice_valid && !slice_ready;
        prev_o_stall = out_valid && !out_ready;
        prev_z = slice_z;
        prev_s = slice_out;
        prev_o = out_lane;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds blk[0..16]; in_last raised on lane last_pos (-1: none).
    task automatic absorb(input int last_pos, input bit gaps);
        int b;
        for (int i = 0; i < 17; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                wb_valid = 1'($urandom_range(0, 1));
                wb_z     = 6'($urandom);
                wb_slice = 25'($urandom);
                tick();
                wb_valid = 1'b0;
            end
            in_valid = 1'b1;
            in_lane  = blk[i];
            in_last  = (i == last_pos);
            b = 0;
            @(negedge clk);
            while (!in_ready) begin
                if (++b > 200) abort("absorb handshake");
                @(negedge clk);
            end
            tick();
            model[i] = model[i] ^ blk[i];
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int z = 0; z < 64; z++) exp_slices.push_back('{z: 6'(z), s: model_slice(z)});
    endtask

    task automatic send(input bit hold, input int stop_at);
        int hs = 0, cyc = 0;
        while (hs < stop_at) begin
            slice_ready = hold ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (cyc == 0) check("send latency after last lane", 64'(slice_valid), 64'd1);
            if (slice_valid && slice_ready) hs++;
            if (++cyc > 2000) abort("slice handshake");
            tick();
        end
        slice_ready = 1'b0;
        if (hold && stop_at == 64) check("send cycles with ready held", 64'(cyc), 64'd64);
    endtask

    task automatic perm(input bit identity, input bit last);
        logic [24:0] ns [64];
        int unsigned ord [64];
        int unsigned j, t;
        @(negedge clk);
        check("slice_valid low after 64 slices", 64'(slice_valid), 64'd0);
        check("busy in PERM", 64'(busy), 64'd1);
        tick();
        for (int z = 0; z < 64; z++) begin
            ns[z]  = identity ? model_slice(z) : 25'($urandom);
            ord[z] = identity ? 63 - z : z;
        end
        if (!identity) begin
            for (int i = 63; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
        end
        for (int i = 0; i < 64; i++) begin
            if (!identity && $urandom_range(0, 3) == 0) begin
                wb_valid = 1'b0;
                tick();
            end
            wb_valid = 1'b1;
            wb_z     = 6'(ord[i]);
            wb_slice = ns[ord[i]];
            tick();
        end
        wb_valid = 1'b0;
        for (int z = 0; z < 64; z++)
            for (int k = 0; k < 25; k++) model[k][z] = ns[z][k];
        if (last) begin
            for (int k = 0; k < 4; k++) exp_out.push_back(model[k]);
            for (int k = 0; k < 25; k++) model[k] = '0;
        end
        @(negedge clk);
        if (last) check("out_valid latency after last write-back", 64'(out_valid), 64'd1);
        else      check("in_ready after non-final block", 64'(in_ready), 64'd1);
        tick();
    endtask

    task automatic squeeze();
        int hs = 0, cyc = 0;
        while (hs < 4) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid && out_ready) hs++;
            if (++cyc > 2000) abort("digest handshake");
            tick();
        end
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid low after 4 lanes", 64'(out_valid), 64'd0);
        check("in_ready after squeeze", 64'(in_ready), 64'd1);
        check("busy low after squeeze", 64'(busy), 64'd0);
        tick();
    endtask

    task automatic run_block(input int last_pos, input bit hold, input bit identity, input bit gaps);
        absorb(last_pos, gaps);
        send(hold, 64);
        perm(identity, last_pos >= 0);
        if (last_pos >= 0) squeeze();
    endtask

    task automatic random_blk();
        for (int i = 0; i < 17; i++) blk[i] = {$urandom, $urandom};
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        check({tag, " slice_valid"}, 64'(slice_valid), 64'd0);
        check({tag, " slice_z"}, 64'(slice_z), 64'd0);
        check({tag, " slice_out"}, 64'(slice_out), 64'd0);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " out_lane"}, out_lane, 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        abort("global watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_lane = '0; in_last = 1'b0;
        slice_ready = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_z = '0; wb_slice = '0;
        for (int k = 0; k < 25; k++) model[k] = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        tick();
        rst = 1'b0;
        tick();

        // Lanes 0..16 = 1..17, ready held, reverse-order echo: digest must be 1,2,3,4.
        for (int i = 0; i < 17; i++) blk[i] = 64'(i + 1);
        run_block(16, 1'b1, 1'b1, 1'b0);

        // Two-block message onto random write-back state.
        random_blk(); run_block(-1, 1'b0, 1'b0, 1'b1);
        random_blk(); run_block(16, 1'b0, 1'b0, 1'b1);

        // Three-block message.
        for (int b = 0; b < 3; b++) begin
            random_blk();
            run_block(b == 2 ? 16 : -1, 1'b0, 1'b0, 1'b1);
        end

        // in_last on an early lane only records the flag; the block still completes.
        random_blk(); run_block(5, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of SEND, then an all-zero echoed block must squeeze zeros.
        random_blk();
        absorb(-1, 1'b0);
        send(1'b1, 30);
        #2 rst = 1'b1;
        #1;
        check("mid-send reset slice_valid", 64'(slice_valid), 64'd0);
        check("mid-send reset busy", 64'(busy), 64'd0);
        check("mid-send reset in_ready", 64'(in_ready), 64'd1);
        check("mid-send reset slice_z", 64'(slice_z), 64'd0);
        exp_slices.delete();
        for (int k = 0; k < 25; k++) model[k] = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) blk[i] = '0;
        run_block(16, 1'b0, 1'b1, 1'b0);

        random_blk(); run_block(16, 1'b0, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        check("slice scoreboard drained", 64'(exp_slices.size()), 64'd0);
        check("digest scoreboard drained", 64'(exp_out.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
